// File: rtl/bf_pkg.sv
// Shared opcodes, FSM states and error codes for the Brainfuck execution core.
package bf_pkg;
  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_LOOP  = 8'h5B;
  localparam logic [7:0] OP_END   = 8'h5D;
  localparam logic [7:0] OP_HALT  = 8'h00;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_CELL_RD, S_CELL_WR, S_IO_OUT, S_IO_IN, S_SCAN, S_HALT, S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_UNM  = 2'b11;
endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-start pcs; push when full and pop when empty are dropped.
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [SW-1:0]     r_sp;
  logic [SW-1:0]     w_sp_m1;
  logic              w_do_push;

  assign w_sp_m1   = r_sp - 1'b1;
  assign o_top     = r_mem[w_sp_m1[IW-1:0]];
  assign o_empty   = (r_sp == '0);
  assign o_full    = (r_sp == SW'(DEPTH));
  assign w_do_push = i_push && !o_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_sp <= '0;
    else if (w_do_push)            r_sp <= r_sp + 1'b1;
    else if (i_pop && !o_empty)    r_sp <= w_sp_m1;
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_sp[IW-1:0]] <= i_data;
  end
endmodule

// File: rtl/bf_core_stack.sv
// Brainfuck core: unified program/tape memory on a req/ack bus, hardware loop stack, valid/ready I/O.
module bf_core_stack
  import bf_pkg::*;
#(
  parameter int         DATA_W      = 8,
  parameter int         ADDR_W      = 8,
  parameter int         STACK_DEPTH = 8,
  parameter logic [7:0] TAPE_BASE   = 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              halted,
  output logic [1:0]        error,
  output logic [ADDR_W-1:0] pc_dbg
);
  localparam logic [ADDR_W-1:0] PTR_RST = ADDR_W'(TAPE_BASE);

  state_t            r_state, n_state;
  logic [ADDR_W-1:0] r_pc, n_pc, r_ptr, n_ptr, r_addr, n_addr, r_depth, n_depth;
  logic [DATA_W-1:0] r_cell, n_cell, r_wdata, n_wdata;
  logic [7:0]        r_op, n_op;
  logic              r_req, n_req, r_we, n_we, r_out_valid, n_out_valid;
  logic              r_in_ready, n_in_ready, r_halted, n_halted;
  logic [1:0]        r_err, n_err;
  logic              w_push, w_pop, w_empty, w_full;
  logic [ADDR_W-1:0] w_top;
  logic [7:0]        w_rd_op;

  assign w_rd_op = mem_rdata[7:0];

  bf_loop_stack #(.ADDR_W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_push && ena), .i_pop(w_pop && ena), .i_data(r_pc),
    .o_top(w_top), .o_empty(w_empty), .o_full(w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;   r_pc <= '0;        r_ptr <= PTR_RST;
      r_addr <= '0;         r_depth <= '0;     r_cell <= '0;
      r_wdata <= '0;        r_op <= '0;        r_req <= 1'b0;
      r_we <= 1'b0;         r_out_valid <= 1'b0; r_in_ready <= 1'b0;
      r_halted <= 1'b0;     r_err <= ERR_NONE;
    end else if (ena) begin
      r_state <= n_state;   r_pc <= n_pc;      r_ptr <= n_ptr;
      r_addr <= n_addr;     r_depth <= n_depth; r_cell <= n_cell;
      r_wdata <= n_wdata;   r_op <= n_op;      r_req <= n_req;
      r_we <= n_we;         r_out_valid <= n_out_valid; r_in_ready <= n_in_ready;
      r_halted <= n_halted; r_err <= n_err;
    end
  end

  // Bus states raise req for one transfer and drop it on the ack edge, which
  // guarantees an idle cycle before the next request.
  always_comb begin
    n_state = r_state;  n_pc = r_pc;       n_ptr = r_ptr;     n_addr = r_addr;
    n_depth = r_depth;  n_cell = r_cell;   n_wdata = r_wdata; n_op = r_op;
    n_req = r_req;      n_we = r_we;       n_out_valid = r_out_valid;
    n_in_ready = r_in_ready; n_halted = r_halted; n_err = r_err;
    w_push = 1'b0;      w_pop = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!r_req) begin
          n_req = 1'b1; n_we = 1'b0; n_addr = r_pc;
        end else if (mem_ack) begin
          n_req = 1'b0; n_op = w_rd_op; n_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (r_op)
          OP_RIGHT: begin n_ptr = r_ptr + 1'b1; n_pc = r_pc + 1'b1; n_state = S_FETCH; end
          OP_LEFT:  begin n_ptr = r_ptr - 1'b1; n_pc = r_pc + 1'b1; n_state = S_FETCH; end
          OP_INC, OP_DEC, OP_OUT, OP_LOOP, OP_END: n_state = S_CELL_RD;
          OP_IN:    begin n_in_ready = 1'b1; n_state = S_IO_IN; end
          OP_HALT:  begin n_halted = 1'b1; n_state = S_HALT; end
          default:  begin n_pc = r_pc + 1'b1; n_state = S_FETCH; end
        endcase
      end
      S_CELL_RD: begin
        if (!r_req) begin
          n_req = 1'b1; n_we = 1'b0; n_addr = r_ptr;
        end else if (mem_ack) begin
          n_req  = 1'b0;
          n_cell = mem_rdata;
          n_pc   = r_pc + 1'b1;
          n_state = S_FETCH;
          case (r_op)
            OP_INC: begin n_cell = mem_rdata + 1'b1; n_pc = r_pc; n_state = S_CELL_WR; end
            OP_DEC: begin n_cell = mem_rdata - 1'b1; n_pc = r_pc; n_state = S_CELL_WR; end
            OP_OUT: begin n_out_valid = 1'b1; n_pc = r_pc; n_state = S_IO_OUT; end
            OP_LOOP: begin
              if (mem_rdata == '0) begin
                n_depth = ADDR_W'(1); n_state = S_SCAN;
              end else if (w_full) begin
                n_err = ERR_OVF; n_pc = r_pc; n_state = S_ERROR;
              end else begin
                w_push = 1'b1;
              end
            end
            default: begin
              if (w_empty) begin
                n_err = ERR_UNF; n_pc = r_pc; n_state = S_ERROR;
              end else if (mem_rdata != '0) begin
                n_pc = w_top + 1'b1;  // re-enter the body without refetching '['
              end else begin
                w_pop = 1'b1;
              end
            end
          endcase
        end
      end
      S_CELL_WR: begin
        if (!r_req) begin
          n_req = 1'b1; n_we = 1'b1; n_addr = r_ptr; n_wdata = r_cell;
        end else if (mem_ack) begin
          n_req = 1'b0; n_we = 1'b0; n_pc = r_pc + 1'b1; n_state = S_FETCH;
        end
      end
      S_IO_OUT: begin
        if (out_ready) begin
          n_out_valid = 1'b0; n_pc = r_pc + 1'b1; n_state = S_FETCH;
        end
      end
      S_IO_IN: begin
        if (in_valid) begin
          n_in_ready = 1'b0; n_cell = in_data; n_state = S_CELL_WR;
        end
      end
      S_SCAN: begin
        if (!r_req) begin
          n_req = 1'b1; n_we = 1'b0; n_addr = r_pc;
        end else if (mem_ack) begin
          n_req = 1'b0;
          n_pc  = r_pc + 1'b1;
          if (w_rd_op == OP_LOOP)     n_depth = r_depth + 1'b1;
          else if (w_rd_op == OP_END) n_depth = r_depth - 1'b1;
          if (w_rd_op == OP_END && r_depth == ADDR_W'(1)) begin
            n_state = S_FETCH;
          end else if (r_pc == '1) begin
            n_err = ERR_UNM; n_state = S_ERROR;
          end
        end
      end
      default: ;
    endcase
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign out_data  = r_cell;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign halted    = r_halted;
  assign error     = r_err;
  assign pc_dbg    = r_pc;
endmodule

// File: tb/tb_bf_core_stack.sv
// Bench for bf_core_stack: memory models with programmable ack latency, output scoreboard, bus-rule monitor.
module tb_bf_core_stack;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ena;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: default parameters ----------------
  logic       rst_a, req_a, we_a, ack_a, out_valid_a, out_ready_a, in_valid_a, in_ready_a, halted_a;
  logic [7:0] addr_a, wdata_a, rdata_a, out_data_a, in_data_a, pc_a;
  logic [1:0] error_a;
  logic [7:0] mem_a [256];
  logic [7:0] img_a [256];
  logic       ld_a;
  int         lat_a, cnt_a, rdy_dly;
  logic [7:0] exp_q [$];

  bf_core_stack dut_a (
    .clk(clk), .rst_n(rst_a), .ena(ena),
    .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_rdata(rdata_a), .mem_ack(ack_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .halted(halted_a), .error(error_a), .pc_dbg(pc_a)
  );

  assign ack_a   = req_a && (cnt_a >= lat_a);
  assign rdata_a = mem_a[addr_a];

  always @(posedge clk) begin
    if (!req_a || (ack_a && ena)) cnt_a <= 0;
    else                          cnt_a <= cnt_a + 1;
    if (ld_a) mem_a <= img_a;
    else if (req_a && ack_a && ena && we_a) mem_a[addr_a] <= wdata_a;
  end

  // Bus-rule monitor: stable while waiting, gap after each completed transfer.
  int         bus_viol = 0, trace_cnt = 0;
  logic       p_req = 1'b0, p_xfer = 1'b0, p_rst = 1'b0, p_we = 1'b0;
  logic [7:0] p_addr = '0, p_wd = '0;
  always @(negedge clk) begin
    if (rst_a && p_rst && p_req) begin
      if (p_xfer) begin
        if (req_a) bus_viol <= bus_viol + 1;
      end else if (!req_a || addr_a != p_addr || we_a != p_we || wdata_a != p_wd) begin
        bus_viol <= bus_viol + 1;
      end
    end
    if (rst_a && req_a && ack_a && ena && !we_a && addr_a == 8'd2) trace_cnt <= trace_cnt + 1;
    p_req <= req_a; p_xfer <= req_a && ack_a && ena; p_rst <= rst_a;
    p_addr <= addr_a; p_we <= we_a; p_wd <= wdata_a;
  end

  // Output consumer: ready after rdy_dly cycles, scoreboard compare at the handshake.
  initial begin
    out_ready_a = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a && out_valid_a && !out_ready_a) begin
        repeat (rdy_dly) @(posedge clk);
        #1 out_ready_a = 1'b1;
        @(negedge clk);
        if (exp_q.size() == 0) chk("out_extra", 64'(out_valid_a), 64'd0);
        else                   chk("out_data", 64'(out_data_a), 64'(exp_q.pop_front()));
        @(posedge clk);
        #1 out_ready_a = 1'b0;
      end
    end
  end

  task automatic boot_a(input string prog, input int lat);
    @(posedge clk); #1 rst_a = 1'b0;
    foreach (img_a[i]) img_a[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) img_a[i] = prog[i];
    ld_a = 1'b1; lat_a = lat;
    @(posedge clk); #1 ld_a = 1'b0;
    @(posedge clk); #1 rst_a = 1'b1;
  endtask

  task automatic run_a(input string tag);
    int n = 0;
    while (n < 3000 && !halted_a && error_a == 2'b00) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(halted_a || error_a != 2'b00), 64'd1);
  endtask

  // ---------------- DUT B: shallow stack, 4-bit addresses ----------------
  logic       rst_b, req_b, we_b, out_valid_b, in_ready_b, halted_b;
  logic [3:0] addr_b, pc_b;
  logic [7:0] wdata_b, rdata_b, out_data_b;
  logic [1:0] error_b;
  logic [7:0] mem_b [16];
  logic [7:0] img_b [16];
  logic       ld_b;

  bf_core_stack #(.DATA_W(8), .ADDR_W(4), .STACK_DEPTH(2), .TAPE_BASE(8'h0F)) dut_b (
    .clk(clk), .rst_n(rst_b), .ena(ena),
    .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_rdata(rdata_b), .mem_ack(req_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(1'b1),
    .in_data(8'h00), .in_valid(1'b0), .in_ready(in_ready_b),
    .halted(halted_b), .error(error_b), .pc_dbg(pc_b)
  );

  assign rdata_b = mem_b[addr_b];
  always @(posedge clk) begin
    if (ld_b) mem_b <= img_b;
    else if (req_b && ena && we_b) mem_b[addr_b] <= wdata_b;
  end

  task automatic boot_b(input string prog);
    @(posedge clk); #1 rst_b = 1'b0;
    foreach (img_b[i]) img_b[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) img_b[i] = prog[i];
    ld_b = 1'b1;
    @(posedge clk); #1 ld_b = 1'b0;
    @(posedge clk); #1 rst_b = 1'b1;
    for (int n = 0; n < 500 && !halted_b && error_b == 2'b00; n++) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pc_s, addr_s;
    int b0, nreq;
    rst_a = 1'b0; rst_b = 1'b0; ena = 1'b1; ld_a = 1'b0; ld_b = 1'b0;
    lat_a = 0; rdy_dly = 0; in_valid_a = 1'b0; in_data_a = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_outs", 64'({req_a, we_a, addr_a, wdata_a, out_valid_a, out_data_a,
                          in_ready_a, halted_a, error_a, pc_a}), 64'd0);
    chk("rst_ptr", 64'(dut_a.r_ptr), 64'h80);

    // "+++." then halt
    exp_q.push_back(8'd3);
    boot_a("+++.", 0);
    run_a("t1");
    chk("t1_halted", 64'(halted_a), 64'd1);
    chk("t1_error", 64'(error_a), 64'd0);
    chk("t1_cell", 64'(mem_a[8'h80]), 64'd3);

    // move loop: two iterations, '[' fetched exactly once
    b0 = trace_cnt;
    boot_a("++[->+<]", 0);
    run_a("t2");
    chk("t2_c80", 64'(mem_a[8'h80]), 64'd0);
    chk("t2_c81", 64'(mem_a[8'h81]), 64'd2);
    chk("t2_lbr_fetches", 64'(trace_cnt - b0), 64'd1);
    chk("t2_stack_empty", 64'(dut_a.u_stack.o_empty), 64'd1);

    // nested skip with zero cell
    exp_q.push_back(8'd1);
    boot_a("[+[+]+]+.", 0);
    run_a("t3");
    chk("t3_halted", 64'(halted_a), 64'd1);

    // ']' on empty stack
    boot_a("]", 0);
    run_a("t4");
    chk("t4_error", 64'(error_a), 64'd2);
    chk("t4_halted", 64'(halted_a), 64'd0);

    // slow bus, delayed input/output, ena freeze during the first fetch
    exp_q.push_back(8'hA5);
    rdy_dly = 4;
    boot_a(",.", 3);
    for (int n = 0; n < 20 && !req_a; n++) @(negedge clk);
    @(posedge clk); #1 ena = 1'b0;
    pc_s = pc_a; addr_s = addr_a;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ena_hold", 64'({req_a, addr_a, pc_a, in_ready_a}), 64'({1'b1, addr_s, pc_s, 1'b0}));
      if (k < 2) @(posedge clk);
    end
    @(posedge clk); #1 ena = 1'b1;
    for (int n = 0; n < 100 && !in_ready_a; n++) @(negedge clk);
    chk("t5_in_ready", 64'(in_ready_a), 64'd1);
    repeat (5) @(posedge clk);
    #1 in_valid_a = 1'b1; in_data_a = 8'hA5;
    @(posedge clk); #1 in_valid_a = 1'b0; in_data_a = 8'h00;
    run_a("t5");
    chk("t5_cell", 64'(mem_a[8'h80]), 64'hA5);
    chk("t5_halted", 64'(halted_a), 64'd1);
    rdy_dly = 0;

    // reset in the middle of an endless loop
    boot_a(">>+[]", 1);
    repeat (60) @(posedge clk);
    #3 rst_a = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({req_a, we_a, addr_a, wdata_a, out_valid_a, out_data_a,
                              in_ready_a, halted_a, error_a, pc_a}), 64'd0);
    chk("mid_rst_ptr", 64'(dut_a.r_ptr), 64'h80);

    // DUT B: overflow on third '[' with depth-2 stack, then bus goes quiet
    boot_b("+[[[");
    chk("t7_error", 64'(error_b), 64'd1);
    chk("t7_pc", 64'(pc_b), 64'd3);
    nreq = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_b) nreq++;
    end
    chk("t7_no_req", 64'(nreq), 64'd0);

    // DUT B: unmatched '[' scan wraps pc
    boot_b("[aaaaaaaaaaaaaa");
    chk("t8_error", 64'(error_b), 64'd3);
    chk("t8_halted", 64'(halted_b), 64'd0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("bus_rules", 64'(bus_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bf_core_stack.md
Name: bf_core_stack

Overview:
- Parametrised next-generation Brainfuck execution core. Fetches 8-bit opcodes and operates on a tape, both in one unified memory behind a req/ack bus.
- Data width, address width and loop-stack depth are generalised.
- Adds a hardware bracket stack: backward jumps take one cycle, with no rescan.
- Adds valid/ready byte I/O for '.' and ','.
- Sits between the tt_um top-level pin muxing and external memory.

Parameters:
- DATA_W, 8: tape cell width. Opcodes are always the low 8 bits of mem_rdata.
- ADDR_W, 8: width of pc, tape pointer and memory address.
- STACK_DEPTH, 8: loop-stack entries (power of 2, at least 2).
- TAPE_BASE, 8'h80: reset value of the tape pointer, zero-extended to ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  run enable; low freezes all state and outputs
- mem_req  out  1  bus request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ack = 1
- mem_ack  in  1  transfer completes on a clk edge where mem_req & mem_ack
- out_data  out  DATA_W  '.' output byte/cell
- out_valid  out  1  output valid
- out_ready  in  1  output accept
- in_data  in  DATA_W  ',' input cell
- in_valid  in  1  input valid
- in_ready  out  1  input accept
- halted  out  1  sticky; program reached opcode 8'h00
- error  out  2  sticky; 01 = stack overflow, 10 = ']' with empty stack, 11 = unmatched '[' (scan wrapped pc to 0)
- pc_dbg  out  ADDR_W  current pc

Behaviour:
- Reset (async, rst_n = 0):
  - pc = 0, ptr = TAPE_BASE, stack pointer sp = 0, depth = 0, state = FETCH.
  - All outputs 0, except mem_addr = 0 and pc_dbg = 0.
- Bus rules:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the ack edge.
  - mem_req drops for at least one cycle between transfers.
  - mem_rdata is captured only on the ack edge.
- ena = 0: no register updates and outputs hold. An asserted mem_req stays asserted, and an ack during ena = 0 is ignored.
- States:
  - FETCH: read at pc; the opcode is latched on ack. Then DECODE.
  - DECODE (1 cycle):
    - '>' / '<': ptr ±1 mod 2^ADDR_W, pc+1, FETCH.
    - '+' / '-' / '.' / '[' / ']': CELL_RD.
    - ',': IO_IN.
    - 8'h00: HALT.
    - Any other byte is a comment: pc+1, FETCH.
  - CELL_RD: read at ptr, cell latched. Then:
    - '+' / '-': cell ±1 mod 2^DATA_W, CELL_WR.
    - '.': IO_OUT.
    - '[' with cell != 0: if sp == STACK_DEPTH, ERROR(01); else push pc, sp+1, pc+1, FETCH.
    - '[' with cell == 0: depth = 1, pc+1, SCAN.
    - ']' with sp == 0: ERROR(10).
    - ']' with cell != 0: pc = stack[sp-1] + 1, FETCH; no pop, the loop re-enters directly.
    - ']' with cell == 0: pop (sp-1), pc+1, FETCH.
  - CELL_WR: write cell at ptr; pc+1, FETCH.
  - IO_OUT: out_valid = 1, out_data = cell. Holds until out_ready; then pc+1, FETCH.
  - IO_IN: in_ready = 1. On in_valid, cell = in_data; CELL_WR.
  - SCAN: fetch at pc each step.
    - '[' gives depth+1; ']' gives depth-1.
    - If ']' brings depth to 0: pc+1, FETCH.
    - Otherwise pc+1 and keep scanning.
    - If pc wraps from all-ones to 0 while depth != 0: ERROR(11).
    - depth is ADDR_W bits.
  - HALT, ERROR: terminal. No bus requests; halted or error held until reset.
- Performance: '>' / '<' take FETCH + DECODE, i.e. 2 bus-free cycles plus fetch latency.
- pc wraps mod 2^ADDR_W in normal execution, with no error.
- Reset mid-transfer aborts immediately; mem_req drops asynchronously.

Decomposition:
- Shared package bf_pkg:
  - opcode localparams (OP_INC 8'h2B, OP_DEC 8'h2D, OP_RIGHT 8'h3E, OP_LEFT 8'h3C, OP_OUT 8'h2E, OP_IN 8'h2C, OP_LOOP 8'h5B, OP_END 8'h5D, OP_HALT 8'h00)
  - state enum
  - error code constants
- One sub-module: bf_loop_stack.
  - Parameterised LIFO of ADDR_W × STACK_DEPTH.
  - Interface: push, pop, top, empty and full.
  - Asynchronous active-low reset; push-when-full and pop-when-empty are ignored.

Test Plan:
- Program "+++." at address 0, tape at 0x80, 1-cycle ack → out_valid with out_data = 3; after out_ready, opcode 0x00 gives halted = 1 and mem[0x80] = 3.
- "++[->+<]" then 0x00 → mem[0x80] = 0, mem[0x81] = 2. Loop-back jumps do not re-read the '[' opcode, checked via bus trace. The stack is empty at the end.
- "[+[+]+]+." with cell 0 → scan skips the nested loops (depth reaches 2, then 0); out_data = 1.
- STACK_DEPTH = 2, program "+[[[" → error = 01 on the third '['; mem_req stays 0 afterwards.
- "]" as the first opcode → error = 10. With ADDR_W = 4, "[" followed by 15 comment bytes → scan wraps and error = 11.
- "," then "." with in_valid delayed 5 cycles (in_data = 8'hA5), ack delayed 3 cycles and out_ready delayed 4 cycles → out_data = A5. Bus signals stay stable while waiting. Toggling ena low for 3 cycles mid-fetch changes no state. Asserting rst_n low mid-run gives pc = 0, ptr = 0x80 and all outputs 0.
